hazard_ctrl: RTL and testbench

Pipeline hazard and stall controller for the 5-stage core. It produces the write enables, flushes and bubble-insert (`nop`) controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It sequences load-use bubbles, instruction- and data-cache miss freezes, taken-branch flushes, and the halt drain. It sits beside the ID stage; its `idex_nop` output drives the `nop` input of the ID/EX pipeline register.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/sat_counter16.sv | 22 ++
 rtl/hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_hazard_ctrl.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared pipeline-control definitions: FSM state encoding, zero-register
// index and the default register-index width.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_DFREEZE = 2'b01,
    ST_HALT    = 2'b10
  } state_e;

  localparam int unsigned REG_W_DEF = 4;
  localparam logic [3:0]  REG_ZERO  = 4'h0;

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at 16'hFFFF instead of wrapping.
module sat_counter16 (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        inc,
  output logic [15:0] cnt
);

  logic [15:0] cnt_q;

  // Count one per asserted inc, holding at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (inc && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard and stall controller for the 5-stage core: load-use
// bubbles, I/D-cache miss freezes, taken-branch flushes and halt drain.
// Optional event counters are compiled in with HAZARD_CTRL_STATS_EN.
module hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_W = REG_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             idex_memread,
  input  logic [REG_W-1:0] idex_dst,
  input  logic [REG_W-1:0] ifid_src1,
  input  logic [REG_W-1:0] ifid_src2,
  input  logic             ifid_src1_used,
  input  logic             ifid_src2_used,
  input  logic             branch_taken,
  input  logic             halt_id,
  input  logic             halt_wb,
  input  logic             icache_stall,
  input  logic             dcache_stall,
  output logic             pc_wen,
  output logic             ifid_wen,
  output logic             ifid_flush,
  output logic             idex_nop,
  output logic             back_wen,
  output logic             halted
`ifdef HAZARD_CTRL_STATS_EN
  ,
  output logic [15:0]      lu_stall_cnt,
  output logic [15:0]      dfreeze_cnt
`endif
);

  state_e state_q, state_d;
  logic   halt_seen_q, halt_seen_d;
  // Low from reset until the first clock edge after release; holds the
  // reset output pattern during that window.
  logic   init_q;
  logic   load_use;

  assign load_use = idex_memread && (idex_dst != REG_W'(REG_ZERO)) &&
                    ((ifid_src1_used && (idex_dst == ifid_src1)) ||
                     (ifid_src2_used && (idex_dst == ifid_src2)));

  // State, halt-seen flag and post-reset qualifier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      halt_seen_q <= 1'b0;
      init_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      halt_seen_q <= halt_seen_d;
      init_q      <= 1'b1;
    end
  end

  // Prioritised Mealy control. DFREEZE without a stall falls through to the
  // RUN rules, which is why both states share the dcache_stall branch.
  always_comb begin
    pc_wen      = 1'b0;
    ifid_wen    = 1'b0;
    back_wen    = 1'b0;
    idex_nop    = 1'b1;
    ifid_flush  = 1'b1;
    state_d     = state_q;
    halt_seen_d = halt_seen_q;
    if (!init_q) begin
      // reset pattern
    end else if (state_q == ST_HALT) begin
      idex_nop   = 1'b0;
      ifid_flush = 1'b0;
    end else if (dcache_stall) begin
      idex_nop   = 1'b0;
      ifid_flush = 1'b0;
      state_d    = ST_DFREEZE;
    end else begin
      state_d = ST_RUN;
      if (halt_wb) begin
        ifid_wen   = 1'b1;
        back_wen   = 1'b1;
        idex_nop   = 1'b0;
        ifid_flush = 1'b0;
        state_d    = ST_HALT;
      end else if (load_use) begin
        back_wen   = 1'b1;
        ifid_flush = 1'b0;
      end else if (branch_taken) begin
        pc_wen   = 1'b1;
        ifid_wen = 1'b1;
        back_wen = 1'b1;
        idex_nop = 1'b0;
      end else if (icache_stall || halt_seen_q) begin
        ifid_wen = 1'b1;
        back_wen = 1'b1;
        idex_nop = 1'b0;
      end else begin
        pc_wen     = 1'b1;
        ifid_wen   = 1'b1;
        back_wen   = 1'b1;
        idex_nop   = 1'b0;
        ifid_flush = 1'b0;
      end
      if (halt_id && ifid_wen) begin
        halt_seen_d = 1'b1;
      end
    end
  end

  assign halted = (state_q == ST_HALT);

`ifdef HAZARD_CTRL_STATS_EN
  logic lu_bubble;
  logic dfreeze_act;

  // A load-use bubble is the only case with both idex_nop and back_wen set.
  assign lu_bubble   = idex_nop && back_wen;
  assign dfreeze_act = init_q && (state_q != ST_HALT) && dcache_stall;

  sat_counter16 u_lu_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (lu_bubble),
    .cnt   (lu_stall_cnt)
  );

  sat_counter16 u_df_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (dfreeze_act),
    .cnt   (dfreeze_cnt)
  );
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: directed scenarios then random
// stimulus, all compared against a rule-table reference model.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       idex_memread;
  logic [3:0] idex_dst, ifid_src1, ifid_src2;
  logic       ifid_src1_used, ifid_src2_used;
  logic       branch_taken, halt_id, halt_wb, icache_stall, dcache_stall;
  logic       pc_wen, ifid_wen, ifid_flush, idex_nop, back_wen, halted;
`ifdef HAZARD_CTRL_STATS_EN
  logic [15:0] lu_stall_cnt, dfreeze_cnt;
`endif

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_W(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .idex_memread   (idex_memread),
    .idex_dst       (idex_dst),
    .ifid_src1      (ifid_src1),
    .ifid_src2      (ifid_src2),
    .ifid_src1_used (ifid_src1_used),
    .ifid_src2_used (ifid_src2_used),
    .branch_taken   (branch_taken),
    .halt_id        (halt_id),
    .halt_wb        (halt_wb),
    .icache_stall   (icache_stall),
    .dcache_stall   (dcache_stall),
    .pc_wen         (pc_wen),
    .ifid_wen       (ifid_wen),
    .ifid_flush     (ifid_flush),
    .idex_nop       (idex_nop),
    .back_wen       (back_wen),
    .halted         (halted)
`ifdef HAZARD_CTRL_STATS_EN
    ,
    .lu_stall_cnt   (lu_stall_cnt),
    .dfreeze_cnt    (dfreeze_cnt)
`endif
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  // Reference model state: out of reset window, halted, HLT observed in ID.
  bit          m_started, m_halted, m_seen;
  int unsigned m_lu, m_df;
  // Expected outputs, pattern order {pc, ifid_wen, back, nop, flush}.
  logic [4:0]  e_pat;
  logic        e_halted;
  bit          e_bubble;

  function automatic bit hazard();
    logic [3:0] src [2];
    bit         used [2];
    src[0] = ifid_src1; src[1] = ifid_src2;
    used[0] = ifid_src1_used; used[1] = ifid_src2_used;
    if (!idex_memread || idex_dst == 4'd0) return 0;
    for (int i = 0; i < 2; i++)
      if (used[i] && src[i] == idex_dst) return 1;
    return 0;
  endfunction

  // Pick the expected output pattern from the first rule that matches.
  task automatic model_outputs();
    e_bubble = 0;
    e_halted = m_halted;
    if (!m_started)                      e_pat = 5'b00011;
    else if (m_halted)                   e_pat = 5'b00000;
    else if (dcache_stall)               e_pat = 5'b00000;
    else if (halt_wb)                    e_pat = 5'b01100;
    else if (hazard()) begin             e_pat = 5'b00110; e_bubble = 1; end
    else if (branch_taken)               e_pat = 5'b11101;
    else if (icache_stall || m_seen)     e_pat = 5'b01101;
    else                                 e_pat = 5'b11100;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("pc_wen",     pc_wen,     e_pat[4]);
    chk("ifid_wen",   ifid_wen,   e_pat[3]);
    chk("back_wen",   back_wen,   e_pat[2]);
    chk("idex_nop",   idex_nop,   e_pat[1]);
    chk("ifid_flush", ifid_flush, e_pat[0]);
    chk("halted",     halted,     e_halted);
`ifdef HAZARD_CTRL_STATS_EN
    vectors++;
    assert (lu_stall_cnt === 16'(m_lu)) else begin
      miscompares++;
      $error("FAIL lu_stall_cnt observed=%0d expected=%0d", lu_stall_cnt, m_lu);
    end
    vectors++;
    assert (dfreeze_cnt === 16'(m_df)) else begin
      miscompares++;
      $error("FAIL dfreeze_cnt observed=%0d expected=%0d", dfreeze_cnt, m_df);
    end
`endif
  endtask

  // Entry/exit at posedge+1: drive, check at negedge, advance model on edge.
  task automatic step(input logic mr, input logic [3:0] dst, input logic [3:0] s1,
                      input logic [3:0] s2, input logic u1, input logic u2,
                      input logic br, input logic hid, input logic hwb,
                      input logic ic, input logic dc);
    bit n_halted, n_seen;
    idex_memread = mr; idex_dst = dst; ifid_src1 = s1; ifid_src2 = s2;
    ifid_src1_used = u1; ifid_src2_used = u2; branch_taken = br;
    halt_id = hid; halt_wb = hwb; icache_stall = ic; dcache_stall = dc;
    #4;
    model_outputs();
    check_all();
    n_halted = m_halted;
    n_seen   = m_seen;
    if (m_started && !m_halted) begin
      if (dc) begin
        if (m_df < 65535) m_df++;
      end else begin
        if (hwb) n_halted = 1;
        if (hid && e_pat[3]) n_seen = 1;
        if (e_bubble && m_lu < 65535) m_lu++;
      end
    end
    @(posedge clk);
    m_started = 1;
    m_halted  = n_halted;
    m_seen    = n_seen;
    #1;
  endtask

  task automatic idle(input logic hid, input logic hwb, input logic ic, input logic dc);
    step(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, hid, hwb, ic, dc);
  endtask

  // Asserts reset away from the clock edge and checks the async response.
  task automatic do_reset();
    rst_n = 1'b0;
    idex_memread = 0; idex_dst = 0; ifid_src1 = 0; ifid_src2 = 0;
    ifid_src1_used = 0; ifid_src2_used = 0; branch_taken = 0;
    halt_id = 0; halt_wb = 0; icache_stall = 0; dcache_stall = 0;
    #1;
    m_started = 0; m_halted = 0; m_seen = 0; m_lu = 0; m_df = 0;
    model_outputs();
    check_all();
    @(posedge clk);
    #1;
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    int unsigned halt_cycles;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    do_reset();
    idle(0, 0, 0, 0);                                   // reset pattern held until edge
    idle(0, 0, 0, 0);                                   // full flow

    // Load-use via src2, then full flow.
    step(1, 4'd3, 4'd1, 4'd3, 1, 1, 0, 0, 0, 0, 0);
    idle(0, 0, 0, 0);
    // Via src1.
    step(1, 4'd5, 4'd5, 4'd2, 1, 0, 0, 0, 0, 0, 0);
    // Zero register and unused source: no stall.
    step(1, 4'd0, 4'd0, 4'd0, 1, 1, 0, 0, 0, 0, 0);
    step(1, 4'd3, 4'd1, 4'd3, 1, 0, 0, 0, 0, 0, 0);
    step(0, 4'd3, 4'd1, 4'd3, 1, 1, 0, 0, 0, 0, 0);

    // Data miss for 4 cycles, then resume.
    repeat (4) idle(0, 0, 0, 1);
    idle(0, 0, 0, 0);

    // Branch with hazard: bubble only; branch next cycle.
    step(1, 4'd7, 4'd7, 4'd0, 1, 0, 1, 0, 0, 0, 0);
    step(0, 4'd7, 4'd7, 4'd0, 1, 0, 1, 0, 0, 0, 0);
    // Instruction-cache miss.
    idle(0, 0, 1, 0);
    idle(0, 0, 0, 0);

    // Halt drain: halt_id, then pc frozen and flushing, halt_wb under a freeze.
    idle(1, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 0, 0);
    idle(0, 1, 0, 1);
    idle(0, 1, 0, 0);
    idle(0, 0, 0, 0);
    idle(0, 0, 1, 1);
    do_reset();                                         // halted drops immediately
    idle(0, 0, 0, 0);

    // Reset during a data freeze.
    idle(0, 0, 0, 1);
    idle(0, 0, 0, 1);
    do_reset();
    idle(0, 0, 0, 0);

    // Random stimulus, small register range to provoke hazards.
    halt_cycles = 0;
    for (int n = 0; n < 600; n++) begin
      if (m_halted) halt_cycles++;
      if (halt_cycles > 3) begin
        do_reset();
        halt_cycles = 0;
      end
      step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)),
           4'($urandom_range(0, 3)), 4'($urandom_range(0, 3)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 29) == 0),
           1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 4) == 0),
           1'($urandom_range(0, 3) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
